// File: rtl/omsp_spm_viol_handler_pkg.sv
// Shared constants and types for the SPM violation handler: register offsets,
// STATUS bit positions, log depth and the captured violation record.
package omsp_spm_viol_handler_pkg;

  localparam logic [1:0] SPMV_STATUS   = 2'd0;
  localparam logic [1:0] SPMV_ADDR     = 2'd1;
  localparam logic [1:0] SPMV_PC       = 2'd2;
  localparam int         SPMV_NUM_REGS = 3;

  localparam int SPMV_STAT_PEND    = 0;
  localparam int SPMV_STAT_OVF     = 1;
  localparam int SPMV_STAT_WR      = 2;
  localparam int SPMV_STAT_FULL    = 3;
  localparam int SPMV_STAT_CNT_LSB = 8;

  localparam int SPMV_LOG_DEPTH = 2;
  localparam int SPMV_REC_W     = 33;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] mab;
    logic        wr;
  } spmv_rec_t;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_WAIT = 2'd2
  } spmv_irq_state_e;

endpackage

// File: rtl/omsp_spm_viol_fifo.sv
// Small parametrised FIFO holding violation records; a simultaneous pop and
// push is applied pop-first, so a push into a full FIFO succeeds if it pops too.
module omsp_spm_viol_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, so stale data is never observable.
  always_ff @(posedge mclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/omsp_spm_viol_handler.sv
// Logs SPM violations (PC, address, access type) into a 2-entry log, raises
// irq_spm with an accept handshake, and exposes the log on the peripheral bus.
// Optional event counter in STATUS[15:8]: define SPM_VIOLATION_COUNTER_EN.
module omsp_spm_viol_handler #(
  parameter logic [13:0] BASE_ADDR = 14'h00C8
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        violation,
  input  logic [15:0] pc,
  input  logic [15:0] eu_mab,
  input  logic [1:0]  eu_mb_wr,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq_spm,
  input  logic        irq_acc
);

  import omsp_spm_viol_handler_pkg::*;

  localparam int CNT_W = $clog2(SPMV_LOG_DEPTH + 1);

  logic            r_violation_q;
  logic            r_ovf;
  spmv_irq_state_e r_state;
  spmv_irq_state_e w_state_nxt;
  logic            w_viol_evt;
  logic [13:0]     w_off;
  logic            w_sel;
  logic            w_status_wr;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_remain;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  spmv_rec_t       w_rec_in;
  spmv_rec_t       w_head;
  logic [SPMV_REC_W-1:0] w_head_bits;
  logic [7:0]      w_evt_cnt;
  logic [15:0]     w_status;
  logic            w_unused_din;

  assign w_viol_evt  = violation & ~r_violation_q;
  assign w_off       = per_addr - BASE_ADDR;
  assign w_sel       = per_en & (w_off < 14'(SPMV_NUM_REGS));
  assign w_status_wr = w_sel & (w_off[1:0] == SPMV_STATUS) & (|per_we);
  assign w_pop       = w_status_wr & ~w_empty;
  assign w_push      = w_viol_evt & (~w_full | w_pop);
  assign w_drop      = w_viol_evt & w_full & ~w_pop;
  assign w_remain    = (w_count > CNT_W'(1)) | w_push;
  assign w_rec_in    = '{pc: pc, mab: eu_mab, wr: |eu_mb_wr};
  assign w_head      = spmv_rec_t'(w_head_bits);
  assign w_unused_din = ^per_din;

  omsp_spm_viol_fifo #(
    .DEPTH (SPMV_LOG_DEPTH),
    .WIDTH (SPMV_REC_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec_in),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_violation_q <= 1'b0;
      r_ovf         <= 1'b0;
      r_state       <= IRQ_IDLE;
    end else begin
      r_violation_q <= violation;
      r_ovf         <= (r_ovf & ~w_status_wr) | w_drop;
      r_state       <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IRQ_IDLE: if (!w_empty) w_state_nxt = IRQ_REQ;
      IRQ_REQ:  if (irq_acc)  w_state_nxt = IRQ_WAIT;
      IRQ_WAIT: if (w_pop)    w_state_nxt = w_remain ? IRQ_REQ : IRQ_IDLE;
      default:                w_state_nxt = IRQ_IDLE;
    endcase
  end

  assign irq_spm = (r_state == IRQ_REQ);

`ifdef SPM_VIOLATION_COUNTER_EN
  logic [7:0] r_evt_cnt;

  // Counts dropped events as well; only reset clears it.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_evt_cnt <= 8'h00;
    end else if (w_viol_evt && (r_evt_cnt != 8'hFF)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign w_evt_cnt = r_evt_cnt;
`else
  assign w_evt_cnt = 8'h00;
`endif

  always_comb begin
    w_status = 16'h0000;
    w_status[SPMV_STAT_CNT_LSB +: 8] = w_evt_cnt;
    w_status[SPMV_STAT_PEND] = ~w_empty;
    w_status[SPMV_STAT_OVF]  = r_ovf;
    w_status[SPMV_STAT_WR]   = ~w_empty & w_head.wr;
    w_status[SPMV_STAT_FULL] = w_full;
  end

  always_comb begin
    per_dout = 16'h0000;
    if (w_sel) begin
      case (w_off[1:0])
        SPMV_STATUS: per_dout = w_status;
        SPMV_ADDR:   per_dout = w_empty ? 16'h0000 : w_head.mab;
        SPMV_PC:     per_dout = w_empty ? 16'h0000 : w_head.pc;
        default:     per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/omsp_spm_viol_handler.md
# omsp_spm_viol_handler

Downstream consumer of the SPM control block's `violation` output. On each new violation it captures the faulting context (PC, memory address, access type) into a 2-entry log. It raises a maskless interrupt request toward the front-end with an accept handshake. Software reads and retires log entries through the openMSP430 peripheral bus.

## Interface
Parameters:
- `BASE_ADDR`, default 14'h00C8 — peripheral word address of register 0 (byte 0x0190); registers occupy `BASE_ADDR`..`BASE_ADDR+2`.

Ports:
- `mclk` in 1 — single clock; all state on rising edge.
- `puc_rst` in 1 — reset, synchronous, active-high.
- `violation` in 1 — combinational violation flag from SPM control.
- `pc` in 16 — current program counter.
- `eu_mab` in 16 — execution-unit memory address bus.
- `eu_mb_wr` in 2 — execution-unit write strobes; nonzero = write access.
- `per_addr` in 14 — peripheral word address.
- `per_din` in 16 — peripheral write data (ignored; any write to STATUS pops).
- `per_en` in 1 — peripheral access enable.
- `per_we` in 2 — peripheral byte write enables.
- `per_dout` out 16 — read data; 0 when not selected.
- `irq_spm` out 1 — interrupt request.
- `irq_acc` in 1 — interrupt accepted by front-end, one-cycle pulse.

## Operation
- Event detect: `viol_evt = violation & ~violation_q`. `violation_q` is registered; a multi-cycle violation is one event.
- Capture record per event: {`pc`, `eu_mab`, `|eu_mb_wr`}, sampled in the event cycle.
- Log: 2-entry FIFO, oldest at head.
  - Event while full: record dropped, sticky `OVF` set.
  - Pop and event in the same cycle: pop applies first, then push; occupancy unchanged, no overflow.
- Registers, word offsets from `BASE_ADDR`; reads show the head entry, or 0 if the log is empty:
  - 0 STATUS: [0] `PEND` (log non-empty), [1] `OVF`, [2] `WR` (head access was a write), [3] `FULL`, [15:8] count (see Configuration, else 0).
  - 1 ADDR: head `eu_mab`.
  - 2 PC: head `pc`.
- Write to STATUS (any `per_we` nonzero): pops the head if non-empty and clears `OVF`. Writes to ADDR/PC are ignored.
- IRQ FSM:
  - IDLE: `irq_spm`=0. Go to REQ when the log is non-empty.
  - REQ: `irq_spm`=1. On `irq_acc`, go to WAIT.
  - WAIT: `irq_spm`=0. On pop, go to REQ if entries remain after the pop (including a same-cycle push), else IDLE.
  - `irq_acc` outside REQ is ignored.
- Reset: FIFO empty, `OVF`=0, `violation_q`=0, FSM=IDLE, `irq_spm`=0, counter=0. `per_dout` is then 0 for all offsets except STATUS, which reads 0 as well.
- Reset asserted mid-operation discards all entries in the same edge. A violation in a reset cycle is not logged.

## Timing
- Event in cycle N → entry visible on the bus and `PEND`=1 at N+1. `irq_spm`=1 at N+2 (FSM registers the non-empty state).
- `irq_acc` at cycle M → `irq_spm`=0 at M+1.
- Pop write at cycle P → new head, `OVF` cleared, and FSM transition all at P+1.
- `per_dout` is combinational from `per_addr`/`per_en` and the registered state; zero-cycle read latency.
- `violation` held high continuously → exactly one entry; it re-arms only after one low cycle.

## Configuration
- `SPM_VIOLATION_COUNTER_EN` defined:
  - 8-bit counter of all events, including dropped ones.
  - Saturates at 8'hFF and appears in STATUS[15:8].
  - Cleared only by `puc_rst`; not cleared by pop.
- Undefined: no counter; STATUS[15:8] reads 0.

## Structure
- Shared defines file (alongside the existing openMSP430 defines):
  - register offsets `SPMV_STATUS`/`SPMV_ADDR`/`SPMV_PC`
  - STATUS bit positions
  - log depth constant (2)
  - record width (33 bits).
- Sub-module `omsp_spm_viol_fifo`:
  - parametrised-depth FIFO with push/pop/full/empty.
  - Pop-before-push ordering on simultaneous operations.
- FSM, event detect, counter and bus decode stay in the top module.

## Test plan
- Single event: `violation` high 1 cycle, `pc`=16'hC010, `eu_mab`=16'h0200, `eu_mb_wr`=2'b01 → N+1 STATUS=16'h0005, ADDR=16'h0200, PC=16'hC010; `irq_spm`=1 at N+2.
- Handshake: `irq_acc` pulse then STATUS write → `irq_spm` low next cycle; STATUS reads 0 and FSM returns to IDLE after the pop.
- Overflow: three separate events → `FULL`=1, `OVF`=1, head holds the first event. After two pops STATUS=0. With the counter enabled, STATUS[15:8] reads 3 throughout.
- Simultaneous pop and event with the log full → occupancy stays 2, `OVF` stays 0, new head is the former second entry.
- Held violation for 10 cycles, low 1 cycle, high 1 cycle → exactly two entries.
- Reset mid-operation with 2 entries and `irq_spm`=1 → next cycle STATUS=0, `irq_spm`=0, counter=0.
